lfsr_symbol_modulator: RTL

Consumes the 5-bit LFSR state, samples one pseudo-random symbol bit per rising edge of the slow symbol clock, and applies it to the DDS sine stream as ASK, BPSK or FSK. Sits directly downstream of the LFSR and beside the DDS: it returns the FSK phase increment to the DDS and drives the modulated sample to the display/DAC path. It also counts symbols over the 31-state LFSR period and flags an all-zero lockup.

---
 rtl/lab5_mod_pkg.sv | 31 +++
 rtl/sync_edge_detect.sv | 38 +++
 rtl/lfsr_symbol_modulator.sv | 113 +++++++++++
 3 files changed

// File: rtl/lab5_mod_pkg.sv
// Shared types and helpers for the LFSR symbol modulator.
// Holds the mode and state encodings and the saturating negate used by BPSK.
package lab5_mod_pkg;

  typedef enum logic [1:0] {
    MODE_NONE = 2'b00,
    MODE_ASK  = 2'b01,
    MODE_FSK  = 2'b10,
    MODE_BPSK = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_LOCK = 2'b10
  } state_t;

  // Negate a sign-extended w-bit value; the most negative code maps to the
  // most positive one instead of overflowing back onto itself.
  function automatic logic signed [31:0] sat_neg(input logic signed [31:0] x, input int w);
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    max_v = (32'sd1 <<< (w - 1)) - 32'sd1;
    min_v = -max_v - 32'sd1;
    if (x == min_v) begin
      return max_v;
    end
    return -x;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// The output pulse is one clk wide, two edges after the first edge that sees the input high.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic pulse_q, pulse_d;

  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    pulse_d = sync2_q & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/lfsr_symbol_modulator.sv
// Samples the LFSR symbol bit on each symbol-clock rising edge and applies it to
// the DDS sine as ASK, BPSK or FSK; counts symbols and latches an all-zero lockup.
module lfsr_symbol_modulator
  import lab5_mod_pkg::*;
#(
  parameter int                 DATA_W   = 12,
  parameter int                 PHASE_W  = 32,
  parameter int                 LFSR_W   = 5,
  parameter logic [PHASE_W-1:0] FSK_INC0 = PHASE_W'(258),
  parameter logic [PHASE_W-1:0] FSK_INC1 = PHASE_W'(258 * 5)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sym_clk,
  input  logic [LFSR_W-1:0]        lfsr_q,
  input  logic [1:0]               mode,
  input  logic signed [DATA_W-1:0] dds_sin,
  output logic signed [DATA_W-1:0] mod_out,
  output logic [PHASE_W-1:0]       phase_inc,
  output logic                     sym_bit,
  output logic                     sym_valid,
  output logic [LFSR_W-1:0]        sym_count,
  output logic                     lockup
);

  localparam logic [LFSR_W-1:0] CNT_MAX = LFSR_W'((2 ** LFSR_W) - 2);

  logic sample_pulse;

  sync_edge_detect u_sym_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (sym_clk),
    .pulse    (sample_pulse)
  );

  state_t                     state_q,     state_d;
  mode_t                      mode_q,      mode_d;
  logic                       sym_bit_q,   sym_bit_d;
  logic [LFSR_W-1:0]          count_q,     count_d;
  logic                       lockup_q,    lockup_d;
  logic signed [DATA_W-1:0]   mod_out_q,   mod_out_d;
  logic [PHASE_W-1:0]         phase_inc_q, phase_inc_d;
  logic signed [31:0]         din_neg;

  assign din_neg = sat_neg(32'(dds_sin), DATA_W);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    sym_bit_d   = sym_bit_q;
    count_d     = count_q;
    lockup_d    = lockup_q;
    mod_out_d   = '0;
    phase_inc_d = FSK_INC0;

    if (sample_pulse && state_q != S_LOCK) begin
      if (lfsr_q == '0) begin
        state_d   = S_LOCK;
        sym_bit_d = 1'b0;
        lockup_d  = 1'b1;
      end else begin
        state_d   = S_RUN;
        sym_bit_d = lfsr_q[0];
        mode_d    = mode_t'(mode);
        // The first symbol out of IDLE keeps index 0; later ones advance.
        if (state_q == S_RUN) begin
          count_d = (count_q == CNT_MAX) ? '0 : count_q + 1'b1;
        end
      end
    end

    if (state_q == S_RUN) begin
      case (mode_q)
        MODE_ASK:  mod_out_d = sym_bit_q ? dds_sin : '0;
        MODE_BPSK: mod_out_d = sym_bit_q ? dds_sin : DATA_W'(din_neg);
        default:   mod_out_d = dds_sin;
      endcase
      if (mode_q == MODE_FSK && sym_bit_q) begin
        phase_inc_d = FSK_INC1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      mode_q      <= MODE_NONE;
      sym_bit_q   <= 1'b0;
      count_q     <= '0;
      lockup_q    <= 1'b0;
      mod_out_q   <= '0;
      phase_inc_q <= FSK_INC0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      sym_bit_q   <= sym_bit_d;
      count_q     <= count_d;
      lockup_q    <= lockup_d;
      mod_out_q   <= mod_out_d;
      phase_inc_q <= phase_inc_d;
    end
  end

  // Gated by reset so a reset arriving with the pulse never advertises a symbol.
  assign sym_valid = sample_pulse & reset & (state_q != S_LOCK);
  assign mod_out   = mod_out_q;
  assign phase_inc = phase_inc_q;
  assign sym_bit   = sym_bit_q;
  assign sym_count = count_q;
  assign lockup    = lockup_q;

endmodule
